// File: rtl/fifo_reader.sv
// Pop-side companion to the synchronous FIFO: pops on non-empty and re-times words
// into a main + skid output buffer. Optional stall counter: FIFO_READER_STATS_EN.
module fifo_reader #(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_flush,
    input  logic [WIDTH-1:0]    i_fifo_data,
    input  logic                i_fifo_empty,
    output logic                o_fifo_pop,
    output logic [WIDTH-1:0]    o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [1:0]          o_level,
    output logic [CNT_BITS-1:0] o_stall_cnt
);

    // State encoding doubles as the buffered word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             pop;
    logic             take;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first, so no path through the case leaves
    // state_nxt unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (pop) state_nxt = ONE;
                ONE: begin
                    if (pop && !take)      state_nxt = TWO;
                    else if (!pop && take) state_nxt = EMPTY;
                end
                TWO:     if (take) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Pop never fires in TWO, so the buffer cannot overflow.
    always_comb begin
        o_valid    = (state != EMPTY) && !i_flush;
        take       = o_valid && i_ready;
        pop        = !i_fifo_empty && !i_flush && !i_reset && (state != TWO);
        o_fifo_pop = pop;
        o_level    = state;
    end

    // NOTE: the two data registers are reset because o_data must read 0 out of
    // reset; flush leaves their contents stale since o_valid masks them.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            unique case (state)
                EMPTY: if (pop) main_q <= i_fifo_data;
                ONE: begin
                    if (pop && take)       main_q <= i_fifo_data;
                    else if (pop && !take) skid_q <= i_fifo_data;
                end
                TWO:     if (take) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    assign o_data = main_q;

`ifdef FIFO_READER_STATS_EN
    logic [CNT_BITS-1:0] stall_cnt_q;

    // Saturating count of cycles where a valid word is held off by i_ready.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
        end else if (o_valid && !i_ready && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_BITS'(1);
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and scoreboarded bench for fifo_reader; a second instance with
// CNT_BITS=2 exercises stall counter saturation.
module tb_fifo_reader;

    localparam int WIDTH  = 32;
    localparam int N_RAND = 10000;
    localparam int BUDGET = 60000;

    logic             i_clk;
    logic             i_reset;
    logic             i_flush;
    logic [WIDTH-1:0] i_fifo_data;
    logic             i_fifo_empty;
    logic             o_fifo_pop;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             i_ready;
    logic [1:0]       o_level;
    logic [15:0]      o_stall_cnt;

    logic             o_fifo_pop2;
    logic [WIDTH-1:0] o_data2;
    logic             o_valid2;
    logic [1:0]       o_level2;
    logic [1:0]       o_stall_cnt2;

    fifo_reader #(.WIDTH(WIDTH), .CNT_BITS(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
        .o_fifo_pop(o_fifo_pop), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_level(o_level), .o_stall_cnt(o_stall_cnt)
    );

    fifo_reader #(.WIDTH(WIDTH), .CNT_BITS(2)) dut2 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_fifo_data(i_fifo_data), .i_fifo_empty(i_fifo_empty),
        .o_fifo_pop(o_fifo_pop2), .o_data(o_data2), .o_valid(o_valid2),
        .i_ready(i_ready), .o_level(o_level2), .o_stall_cnt(o_stall_cnt2)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int               n_checks = 0;
    int               n_bad    = 0;
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] out_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             gate_empty = 1'b0;
    logic             mon_en     = 1'b0;
    int               viol_pop   = 0;
    int               viol_hold  = 0;
    logic             prev_hold  = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        i_fifo_empty = (fifo_q.size() == 0) || gate_empty;
        i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // Sample just before the edge, commit the edge's pop/take, refresh FIFO inputs.
    task automatic step();
        logic             p;
        logic             tk;
        logic [WIDTH-1:0] d;
        @(negedge i_clk);
        p  = o_fifo_pop;
        tk = o_valid && i_ready;
        d  = o_data;
        if (mon_en) begin
            if (p && ((o_level == 2'd2) || i_fifo_empty)) viol_pop++;
            if (prev_hold && (!o_valid || (o_data !== prev_data))) viol_hold++;
            prev_hold = o_valid && !i_ready;
            prev_data = o_data;
        end
        @(posedge i_clk);
        #1;
        if (p) void'(fifo_q.pop_front());
        if (tk) out_q.push_back(d);
        drive_fifo();
        #1;
    endtask

    initial begin
        int cycles;
        int mism;
        logic [31:0] w;
        logic [31:0] exp_stall;
        logic [31:0] exp_stall2;

        // Reset state, with a non-empty FIFO that must not be popped.
        i_reset = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
        fifo_q = '{32'h11, 32'h22, 32'h33};
        drive_fifo();
        #1;
        check("rst_pop",   o_fifo_pop,  0);
        check("rst_valid", o_valid,     0);
        check("rst_level", o_level,     0);
        check("rst_data",  o_data,      0);
        check("rst_stall", o_stall_cnt, 0);

        // Streaming at full rate.
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        #1;
        check("s_pop0",   o_fifo_pop, 1);
        check("s_valid0", o_valid,    0);
        step();
        check("s_d11", o_data, 32'h11); check("s_v1", o_valid, 1);
        check("s_l1",  o_level, 1);     check("s_p1", o_fifo_pop, 1);
        step();
        check("s_d22", o_data, 32'h22); check("s_l2", o_level, 1); check("s_p2", o_fifo_pop, 1);
        step();
        check("s_d33", o_data, 32'h33); check("s_l3", o_level, 1); check("s_p3", o_fifo_pop, 0);
        step();
        check("s_v_end", o_valid, 0); check("s_l_end", o_level, 0);

        // Back-pressure fill to TWO, then drain without gaps.
        i_ready = 1'b0;
        fifo_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        drive_fifo(); #1;
        step();
        check("bp_dA0", o_data, 32'hA0); check("bp_p1", o_fifo_pop, 1);
        step();
        check("bp_l2", o_level, 2); check("bp_dA0b", o_data, 32'hA0); check("bp_p2", o_fifo_pop, 0);
        step();
        check("bp_hold_l", o_level, 2); check("bp_hold_d", o_data, 32'hA0);
        check("bp_hold_p", o_fifo_pop, 0);
        i_ready = 1'b1; #1;
        check("dr_A0", o_data, 32'hA0);
        step(); check("dr_A1", o_data, 32'hA1); check("dr_vA1", o_valid, 1);
        step(); check("dr_A2", o_data, 32'hA2); check("dr_vA2", o_valid, 1);
        step(); check("dr_A3", o_data, 32'hA3); check("dr_vA3", o_valid, 1);
        step(); check("dr_end", o_valid, 0);

        // Flush out of TWO with the FIFO still non-empty.
        i_ready = 1'b0;
        fifo_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        drive_fifo(); #1;
        step(); step();
        check("fl_l2", o_level, 2);
        i_flush = 1'b1; #1;
        check("fl_valid", o_valid, 0); check("fl_pop", o_fifo_pop, 0);
        step();
        i_flush = 1'b0; #1;
        check("fl_l0", o_level, 0); check("fl_v0", o_valid, 0); check("fl_pop_next", o_fifo_pop, 1);
        i_ready = 1'b1;
        step(); check("fl_dB2", o_data, 32'hB2);
        step(); check("fl_dB3", o_data, 32'hB3);
        step(); check("fl_end", o_valid, 0);

        // Async reset mid-cycle while in ONE.
        i_ready = 1'b0;
        fifo_q.push_back(32'hC0);
        drive_fifo(); #1;
        step();
        check("ar_one", o_level, 1);
        fifo_q.push_back(32'hC1);
        drive_fifo(); #1;
        i_reset = 1'b1; #1;
        check("ar_valid", o_valid, 0); check("ar_level", o_level, 0);
        check("ar_data",  o_data,  0); check("ar_pop",   o_fifo_pop, 0);
        step();
        check("ar_pop_hold", o_fifo_pop, 0); check("ar_level_hold", o_level, 0);
        fifo_q.delete();
        drive_fifo();
        i_reset = 1'b0; #1;

        // Random gating of empty and ready; scoreboard checks order.
        out_q.delete(); exp_q.delete();
        for (int i = 0; i < N_RAND; i++) begin
            w = {16'hD00D ^ 16'(i * 7), 16'(i)};
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        mon_en = 1'b1;
        cycles = 0;
        while ((out_q.size() < N_RAND) && (cycles < BUDGET)) begin
            gate_empty = ($urandom_range(0, 3) == 0);
            i_ready    = ($urandom_range(0, 3) != 0);
            drive_fifo(); #1;
            step();
            cycles++;
        end
        mon_en = 1'b0; gate_empty = 1'b0; i_ready = 1'b1;
        drive_fifo(); #1;
        check("rnd_count", out_q.size(), N_RAND);
        mism = 0;
        for (int i = 0; i < out_q.size() && i < N_RAND; i++)
            if (out_q[i] !== exp_q[i]) mism++;
        check("rnd_order",     mism,      0);
        check("rnd_pop_rule",  viol_pop,  0);
        check("rnd_hold_rule", viol_hold, 0);

        // Stall counter, starting from a fresh reset.
        step();
        i_reset = 1'b1; #1;
        check("st_rst", o_stall_cnt, 0);
        step();
        i_reset = 1'b0; i_ready = 1'b0;
        fifo_q = '{32'hE0};
        drive_fifo(); #1;
        step();
        for (int i = 0; i < 5; i++) step();
`ifdef FIFO_READER_STATS_EN
        exp_stall = 5; exp_stall2 = 3;
`else
        exp_stall = 0; exp_stall2 = 0;
`endif
        check("st_5",      o_stall_cnt,  exp_stall);
        check("st_sat_5",  o_stall_cnt2, exp_stall2);
        step();
`ifdef FIFO_READER_STATS_EN
        exp_stall = 6;
`endif
        check("st_6",     o_stall_cnt,  exp_stall);
        check("st_sat_6", o_stall_cnt2, exp_stall2);
        i_flush = 1'b1; #1;
        step();
        i_flush = 1'b0; #1;
        check("st_flush_keep", o_stall_cnt, exp_stall);
        check("st_flush_lvl",  o_level,     0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
